// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
// The optional round-robin mode is selected by defining SRAM_ARB_RR_EN.
package sram_arb_pkg;

    localparam int N_REQ    = 3;
    localparam int REQ_DATA = 0;
    localparam int REQ_IF   = 1;
    localparam int REQ_DMA  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef logic [1:0] req_idx_t;

    // Encode a one-hot (or zero) winner vector as a requester index.
    function automatic req_idx_t onehot_to_idx(input logic [N_REQ-1:0] oh);
        req_idx_t idx;
        if (oh[REQ_DATA]) begin
            idx = 2'd0;
        end else if (oh[REQ_IF]) begin
            idx = 2'd1;
        end else if (oh[REQ_DMA]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Decode a requester index into its one-hot grant bit.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [N_REQ-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Index that follows idx in the circular requester order.
    function automatic req_idx_t idx_after(input req_idx_t idx);
        req_idx_t nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sram_arb_chk.sv
// Protocol checker for the SRAM arbiter outputs (simulation only).
module sram_arb_chk
    import sram_arb_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input logic [N_REQ-1:0] gnt,
    input logic             busy,
    input logic             mem_drive,
    input logic             mem_enable_n,
    input logic             mem_read_n,
    input logic             mem_write_n
);

    // Grant is a single completion pulse.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt));

    // The SRAM never sees read and write strobes together.
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(!mem_read_n && !mem_write_n));

    // A grant only appears in the strobe-free completion cycle.
    a_gnt_in_done: assert property (@(posedge clk) disable iff (rst)
        (gnt != 3'b000) |-> (busy && mem_enable_n && mem_read_n && mem_write_n));

    // An idle arbiter leaves the bus completely quiet.
    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
        !busy |-> (mem_enable_n && mem_read_n && mem_write_n && !mem_drive
                   && (gnt == 3'b000)));

    // The arbiter never drives the bus while the SRAM is driving it.
    a_read_no_drive: assert property (@(posedge clk) disable iff (rst)
        !mem_read_n |-> !mem_drive);

endmodule

// File: rtl/sram_arb_pick.sv
// Combinational winner selector for the SRAM arbiter.
// Fixed priority data > fetch > DMA by default; with SRAM_ARB_RR_EN the
// search starts at the pointer supplied by the arbiter.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
`ifdef SRAM_ARB_RR_EN
    input  req_idx_t         ptr,
`endif
    output logic [N_REQ-1:0] win
);

    // First active requester when searching in the order a, b, c.
    function automatic logic [N_REQ-1:0] first_in_order(
        input logic [N_REQ-1:0] r,
        input req_idx_t         a,
        input req_idx_t         b,
        input req_idx_t         c
    );
        logic [N_REQ-1:0] f;
        if (r[a]) begin
            f = idx_to_onehot(a);
        end else if (r[b]) begin
            f = idx_to_onehot(b);
        end else if (r[c]) begin
            f = idx_to_onehot(c);
        end else begin
            f = 3'b000;
        end
        return f;
    endfunction

`ifdef SRAM_ARB_RR_EN
    // Rotate the search so it begins just after the last granted requester.
    always_comb begin
        win = 3'b000;
        case (ptr)
            2'd0:    win = first_in_order(req, 2'd0, 2'd1, 2'd2);
            2'd1:    win = first_in_order(req, 2'd1, 2'd2, 2'd0);
            2'd2:    win = first_in_order(req, 2'd2, 2'd0, 2'd1);
            default: win = first_in_order(req, 2'd0, 2'd1, 2'd2);
        endcase
    end
`else
    // Fixed priority: the data port always beats fetch, fetch beats DMA.
    always_comb begin
        win = 3'b000;
        win = first_in_order(req, 2'd0, 2'd1, 2'd2);
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Three-requester arbiter in front of a single asynchronous SRAM.
// Each access: IDLE (arbitrate) -> ACCESS for ACC_CYC cycles -> DONE (grant).
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              we,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]              gnt,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_dout,
    input  logic [DATA_W-1:0]             mem_din,
    output logic                          mem_drive,
    output logic                          mem_enable_n,
    output logic                          mem_read_n,
    output logic                          mem_write_n,
    output logic                          busy
);

    // Counter reload: ACCESS ends when the counter has reached zero.
    localparam logic [2:0] CNT_LOAD = 3'(ACC_CYC - 1);

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic [2:0]        cnt_r;
    logic [2:0]        cnt_s;
    logic              load_s;
    logic              finish_s;

    logic [N_REQ-1:0]  win_s;
    req_idx_t          win_idx_s;
    req_idx_t          lat_idx_r;
    logic              lat_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_dout_r;
    logic [DATA_W-1:0] rdata_r;

    logic              we_nxt_s;
    logic              enable_n_s;
    logic              read_n_s;
    logic              write_n_s;
    logic              drive_s;
    logic              busy_s;
    logic [N_REQ-1:0]  gnt_s;

    logic [N_REQ-1:0]  gnt_r;
    logic              busy_r;
    logic              drive_r;
    logic              enable_n_r;
    logic              read_n_r;
    logic              write_n_r;

`ifdef SRAM_ARB_RR_EN
    req_idx_t          ptr_r;

    sram_arb_pick u_pick (
        .req (req),
        .ptr (ptr_r),
        .win (win_s)
    );

    // Round-robin pointer moves past the requester being granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else if (state_r == DONE) begin
            ptr_r <= idx_after(lat_idx_r);
        end
    end
`else
    sram_arb_pick u_pick (
        .req (req),
        .win (win_s)
    );
`endif

    assign win_idx_s = onehot_to_idx(win_s);

    // State and access-length counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: arbitrate only in IDLE, count down ACCESS, one DONE.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        load_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = ACCESS;
                    cnt_s   = CNT_LOAD;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 3'd0) begin
                    state_s  = DONE;
                    finish_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // strobes can be registered without adding a cycle of latency.
    always_comb begin
        we_nxt_s   = lat_we_r;
        enable_n_s = 1'b1;
        read_n_s   = 1'b1;
        write_n_s  = 1'b1;
        drive_s    = 1'b0;
        gnt_s      = 3'b000;
        busy_s     = 1'b0;
        if (load_s) begin
            we_nxt_s = we[win_idx_s];
        end else begin
            we_nxt_s = lat_we_r;
        end
        case (state_s)
            ACCESS: begin
                enable_n_s = 1'b0;
                read_n_s   = we_nxt_s;
                write_n_s  = ~we_nxt_s;
                drive_s    = we_nxt_s;
                busy_s     = 1'b1;
            end
            DONE: begin
                // Write data stays on the bus one cycle past the strobe.
                drive_s = we_nxt_s;
                busy_s  = 1'b1;
                if (finish_s) begin
                    gnt_s = idx_to_onehot(lat_idx_r);
                end else begin
                    gnt_s = 3'b000;
                end
            end
            default: begin
                enable_n_s = 1'b1;
            end
        endcase
    end

    // Capture the winning request so the requester may change inputs later.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_idx_r  <= 2'd0;
            lat_we_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_dout_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            lat_idx_r  <= win_idx_s;
            lat_we_r   <= we[win_idx_s];
            mem_addr_r <= addr[win_idx_s];
            mem_dout_r <= wdata[win_idx_s];
        end
    end

    // Registered strobes, bus enable, busy flag and grant pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r      <= 3'b000;
            busy_r     <= 1'b0;
            drive_r    <= 1'b0;
            enable_n_r <= 1'b1;
            read_n_r   <= 1'b1;
            write_n_r  <= 1'b1;
        end else begin
            gnt_r      <= gnt_s;
            busy_r     <= busy_s;
            drive_r    <= drive_s;
            enable_n_r <= enable_n_s;
            read_n_r   <= read_n_s;
            write_n_r  <= write_n_s;
        end
    end

    // Read data is sampled at the last ACCESS edge and held until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (finish_s && !lat_we_r) begin
            rdata_r <= mem_din;
        end
    end

    assign gnt          = gnt_r;
    assign busy         = busy_r;
    assign mem_drive    = drive_r;
    assign mem_enable_n = enable_n_r;
    assign mem_read_n   = read_n_r;
    assign mem_write_n  = write_n_r;
    assign mem_addr     = mem_addr_r;
    assign mem_dout     = mem_dout_r;
    assign rdata        = rdata_r;

    sram_arb_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .gnt          (gnt_r),
        .busy         (busy_r),
        .mem_drive    (drive_r),
        .mem_enable_n (enable_n_r),
        .mem_read_n   (read_n_r),
        .mem_write_n  (write_n_r)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: requester drivers push expected
// responses, a transaction-level model predicts who is granted and when,
// and a negedge monitor compares every grant against both.
module tb_sram_arbiter;

    localparam int ACC = 2;
    localparam int TMO = 3000;

    logic              clk;
    logic              rst;
    logic [2:0]        req;
    logic [2:0]        we;
    logic [2:0][17:0]  addr;
    logic [2:0][15:0]  wdata;
    logic [2:0]        gnt;
    logic [15:0]       rdata;
    logic [17:0]       mem_addr;
    logic [15:0]       mem_dout;
    logic [15:0]       mem_din;
    logic              mem_drive;
    logic              mem_enable_n;
    logic              mem_read_n;
    logic              mem_write_n;
    logic              busy;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .ACC_CYC(ACC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_drive    (mem_drive),
        .mem_enable_n (mem_enable_n),
        .mem_read_n   (mem_read_n),
        .mem_write_n  (mem_write_n),
        .busy         (busy)
    );

    typedef struct packed {
        logic        we;
        logic [17:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int win;
        int due;
    } gexp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          busy_end = -1;
    int          free_at = 0;
    int          rr_ptr = 0;
    logic [15:0] last_rd = 16'h0000;

    exp_t        exp_q [3][$];
    gexp_t       gq [$];
    logic [15:0] ref_mem [int];
    logic [15:0] sram [0:255];

    function automatic logic [7:0] sidx(input logic [17:0] a);
        return {a[17:16], a[5:0]};
    endfunction

    // Behavioural asynchronous SRAM.
    assign mem_din = sram[sidx(mem_addr)];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : sram_write
        forever begin
            @(negedge clk);
            if (!mem_enable_n && !mem_write_n) sram[sidx(mem_addr)] = mem_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: when the arbiter is free and someone asks,
    // the first requester in search order wins and completes ACC edges later;
    // the next arbitration can happen ACC+2 edges after this one.
    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                gq.delete();
                free_at  = cyc + 1;
                busy_end = cyc - 1;
                rr_ptr   = 0;
            end else if (cyc >= free_at && req != 3'b000) begin
                int start;
                int w;
`ifdef SRAM_ARB_RR_EN
                start = rr_ptr;
`else
                start = 0;
`endif
                w = -1;
                for (int j = 0; j < 3; j++) begin
                    if (w < 0 && req[(start + j) % 3]) w = (start + j) % 3;
                end
                gq.push_back('{win: w, due: cyc + ACC});
                busy_end = cyc + ACC;
                free_at  = cyc + ACC + 2;
                rr_ptr   = (w + 1) % 3;
            end
        end
    end

    // Monitor: compares grants, read data and per-access strobe shape.
    initial begin : monitor
        int         rd_cnt;
        int         wr_cnt;
        int         dr_cnt;
        int         gi;
        logic [2:0] exp_g;
        exp_t       e;
        rd_cnt = 0;
        wr_cnt = 0;
        dr_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt  = 0;
                wr_cnt  = 0;
                dr_cnt  = 0;
                last_rd = 16'h0000;
            end else begin
                chk("strobe_excl", {31'd0, (!mem_read_n && !mem_write_n)}, 32'd0);
                chk("busy", {31'd0, busy}, {31'd0, (cyc <= busy_end)});
                if (!mem_read_n) rd_cnt++;
                if (!mem_write_n) wr_cnt++;
                if (mem_drive) dr_cnt++;
                exp_g = 3'b000;
                gi = -1;
                if (gq.size() > 0 && gq[0].due == cyc) begin
                    gi = gq[0].win;
                    exp_g = 3'(1 << gi);
                    void'(gq.pop_front());
                end
                if (gnt != 3'b000 || exp_g != 3'b000) chk("gnt", {29'd0, gnt}, {29'd0, exp_g});
                if (gi >= 0 && gnt == exp_g) begin
                    if (exp_q[gi].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: grant %0d with no outstanding request", gi);
                    end else begin
                        e = exp_q[gi].pop_front();
                        chk("mem_addr", {14'd0, mem_addr}, {14'd0, e.addr});
                        if (e.we) begin
                            chk("wr_strobe_cycles", wr_cnt, ACC);
                            chk("drive_cycles", dr_cnt, ACC + 1);
                            chk("rd_strobe_cycles", rd_cnt, 0);
                            chk("mem_dout", {16'd0, mem_dout}, {16'd0, e.data});
                        end else begin
                            chk("rd_strobe_cycles", rd_cnt, ACC);
                            chk("wr_strobe_cycles", wr_cnt, 0);
                            chk("drive_cycles", dr_cnt, 0);
                            last_rd = e.data;
                        end
                        chk("rdata", {16'd0, rdata}, {16'd0, last_rd});
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                    dr_cnt = 0;
                end
            end
        end
    end

    // One transaction: raise the request, push the expected result, wait for
    // the grant (bounded), then release. drop_early releases req in ACCESS.
    task automatic do_txn(input int i, input logic w, input logic [17:0] a,
                          input logic [15:0] d, input bit drop_early);
        exp_t e;
        int   n;
        int   bc;
        e.we   = w;
        e.addr = a;
        e.data = w ? d : ref_mem[int'(a)];
        if (w) ref_mem[int'(a)] = d;
        exp_q[i].push_back(e);
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        req[i]   = 1'b1;
        n  = 0;
        bc = 0;
        while (n < TMO) begin
            @(negedge clk);
            n++;
            if (gnt[i]) break;
            if (drop_early && busy) begin
                bc++;
                if (bc == 2) req[i] = 1'b0;
            end
        end
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL grant_timeout: requester %0d got no grant in %0d cycles", i, TMO);
        end
        req[i] = 1'b0;
    endtask

    task automatic rand_req(input int i, input int count);
        for (int t = 0; t < count; t++) begin
            logic        w;
            logic [17:0] a;
            logic [15:0] d;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            a = {2'(i), 12'h000, 4'($urandom_range(0, 15))};
            d = 16'($urandom);
            do_txn(i, w, a, d, 1'b0);
        end
    endtask

    initial begin : stimulus
        int n;
        rst   = 1'b1;
        req   = 3'b000;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) begin
                logic [17:0] a;
                logic [15:0] v;
                a = {2'(r), 12'h000, 4'(k)};
                v = 16'($urandom);
                sram[sidx(a)]   = v;
                ref_mem[int'(a)] = v;
            end
        end
        sram[sidx(18'h00123)] = 16'hBEEF;
        ref_mem[int'(18'h00123)] = 16'hBEEF;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drive", {31'd0, mem_drive}, 32'd0);
        chk("rst_strobes", {29'd0, mem_enable_n, mem_read_n, mem_write_n}, 32'd7);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_mem_addr", {14'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read from the fetch port.
        do_txn(1, 1'b0, 18'h00123, 16'h0000, 1'b0);
        chk("read_beef", {16'd0, rdata}, 32'h0000BEEF);
        repeat (2) @(negedge clk);

        // Single write from the data port at the top address.
        do_txn(0, 1'b1, 18'h3FFFF, 16'h1234, 1'b0);
        chk("rdata_hold_after_write", {16'd0, rdata}, 32'h0000BEEF);
        repeat (2) @(negedge clk);

        // DMA request released mid-access still completes.
        do_txn(2, 1'b0, 18'h20005, 16'h0000, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_after_drop", {31'd0, busy}, 32'd0);

        // All three requesting together.
        fork
            begin
                for (int t = 0; t < 3; t++) do_txn(0, 1'b0, 18'h00003, 16'h0000, 1'b0);
            end
            begin
                for (int t = 0; t < 3; t++) do_txn(1, 1'b0, 18'h10004, 16'h0000, 1'b0);
            end
            begin
                for (int t = 0; t < 3; t++) do_txn(2, 1'b0, 18'h20006, 16'h0000, 1'b0);
            end
        join
        repeat (3) @(negedge clk);

        // Reset in the second ACCESS cycle of a write aborts it.
        we[0]    = 1'b1;
        addr[0]  = 18'h3FFF0;
        wdata[0] = 16'hDEAD;
        req[0]   = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_access_started", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst    = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {29'd0, mem_enable_n, mem_read_n, mem_write_n}, 32'd7);
        chk("abort_drive", {31'd0, mem_drive}, 32'd0);
        chk("abort_gnt", {29'd0, gnt}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rdata", {16'd0, rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Randomised concurrent traffic.
        fork
            rand_req(0, 25);
            rand_req(1, 25);
            rand_req(2, 25);
        join
        repeat (10) @(negedge clk);

        for (int i = 0; i < 3; i++) chk("outstanding_left", exp_q[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
